// File: rtl/alu_nibble_serial_adder.sv
// rtl/alu_nibble_serial_adder.sv - nibble-serial add/subtract sequencer around an external 4-bit adder slice
//
// Purpose:
//   Accepts an ADD/SUB/ADC/SBB request over a valid/ready handshake and walks the
//   operands through an external combinational 4-bit full-adder slice one nibble
//   per cycle, LSB first. The carry is held between nibbles. The result, with
//   carry/zero/overflow flags, is returned over a valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       request handshake
//   in_a, in_b              operands (DATA_W bits)
//   in_op                   00 ADD, 01 SUB, 10 ADC, 11 SBB
//   in_cin                  carry-in (ADC) / borrow-in (SBB)
//   fa_a, fa_b, fa_cin      nibble operands and carry to the adder slice (0 outside RUN)
//   fa_s, fa_cout           sum nibble and carry-out from the adder slice
//   out_valid/out_ready     result handshake
//   out_sum                 result
//   out_cout                final carry (1 = no borrow for SUB/SBB)
//   out_zero, out_ovf       result-is-zero and two's-complement overflow flags
//
// Configuration macro:
//   ALU_SERIAL_BACK2BACK_EN - when defined, DONE can hand off straight to RUN if a
//   new request arrives in the same cycle the result is taken.

module alu_nibble_serial_adder #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    input  logic              in_cin,
    output logic [3:0]        fa_a,
    output logic [3:0]        fa_b,
    output logic              fa_cin,
    input  logic [3:0]        fa_s,
    input  logic              fa_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              out_zero,
    output logic              out_ovf
);

    localparam int NIBBLES = DATA_W / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_sum;
    logic                r_cout;
    logic                r_zero;
    logic                r_ovf;

    logic                w_accept;
    logic                w_run;
    logic [DATA_W-1:0]   w_b_in;
    logic                w_carry_in;
    logic [DATA_W-1:0]   w_sum_next;

    // Subtraction is A + ~B + 1; the borrow-in of SBB becomes an inverted carry-in.
    assign w_b_in = in_op[0] ? ~in_b : in_b;

    always_comb begin
        w_carry_in = 1'b0;
        case (in_op)
            2'b00:   w_carry_in = 1'b0;
            2'b01:   w_carry_in = 1'b1;
            2'b10:   w_carry_in = in_cin;
            default: w_carry_in = ~in_cin;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_run        = 1'b0;
        fa_a         = 4'd0;
        fa_b         = 4'd0;
        fa_cin       = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_run  = 1'b1;
                fa_a   = r_a[r_idx*4 +: 4];
                fa_b   = r_b[r_idx*4 +: 4];
                fa_cin = r_carry;
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
`ifdef ALU_SERIAL_BACK2BACK_EN
                in_ready = out_ready;
                if (out_ready && in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else if (out_ready) begin
                    w_state_next = S_IDLE;
                end
`else
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sum as it will look after this edge; the final-nibble flags are taken from it
    // so they are registered on the same edge that enters DONE.
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[r_idx*4 +: 4] = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= w_b_in;
            r_carry <= w_carry_in;
            r_idx   <= '0;
        end else if (w_run) begin
            r_sum   <= w_sum_next;
            r_carry <= fa_cout;
            if (r_idx == LAST_IDX) begin
                r_idx  <= '0;
                r_cout <= fa_cout;
                r_zero <= (w_sum_next == '0);
                r_ovf  <= (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                          (w_sum_next[DATA_W-1] != r_a[DATA_W-1]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;
    assign out_zero = r_zero;
    assign out_ovf  = r_ovf;

endmodule
